// File: rtl/cwc_capture_seq.sv
// Capture sequencer for the ChipWatcher sample RAM: pre-trigger ring fill, trigger capture, post-trigger count.
// Latency: arm to first write 1 cycle; last post-trigger write to done 1 cycle.
// Backpressure: none; sample_en qualifies writes, abort cancels the capture and masks the same-cycle write.
module cwc_capture_seq #(
  parameter int RAM_DATA_DEPTH = 4096,
  parameter int ADDR_W         = $clog2(RAM_DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              sample_en,
  input  logic              trig,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [2:0]        state,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W:0]   sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(RAM_DATA_DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LIMIT = (ADDR_W+1)'(RAM_DATA_DEPTH);

  state_t            st_q, st_d;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] post_rem;
  logic              do_arm;
  logic              trig_hit;
  logic              pre_last;

  assign busy     = (st_q == S_PRE) || (st_q == S_ARMED) || (st_q == S_POST);
  assign ram_we   = sample_en & busy & ~abort;
  assign do_arm   = arm & ~abort & ((st_q == S_IDLE) || (st_q == S_DONE));
  assign trig_hit = (st_q == S_ARMED) & trig & ram_we;
  // sample_cnt stays below pre_len_q in PRE_FILL, so its low bits are the pre-fill count
  assign pre_last = (sample_cnt[ADDR_W-1:0] == (pre_len_q - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= S_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (abort) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE, S_DONE: if (arm) st_d = (pre_len == '0) ? S_ARMED : S_PRE;
        S_PRE:          if (ram_we && pre_last) st_d = S_ARMED;
        S_ARMED:        if (trig_hit) st_d = (pre_len_q == LAST) ? S_DONE : S_POST;
        S_POST:         if (ram_we && post_rem == ONE) st_d = S_DONE;
        default:        st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_len_q  <= '0;
      ram_waddr  <= '0;
      sample_cnt <= '0;
      trig_addr  <= '0;
      triggered  <= 1'b0;
      post_rem   <= '0;
    end else if (do_arm) begin
      pre_len_q  <= pre_len;
      ram_waddr  <= '0;
      sample_cnt <= '0;
      trig_addr  <= '0;
      triggered  <= 1'b0;
    end else if (abort) begin
      triggered  <= 1'b0;
    end else if (ram_we) begin
      ram_waddr <= ram_waddr + ONE;
      if (sample_cnt != CNT_LIMIT) sample_cnt <= sample_cnt + CNT_ONE;
      if (trig_hit) begin
        trig_addr <= ram_waddr;
        triggered <= 1'b1;
        post_rem  <= LAST - pre_len_q;
      end
      if (st_q == S_POST) post_rem <= post_rem - ONE;
    end
  end

  assign state      = st_q;
  assign done       = (st_q == S_DONE);
  assign start_addr = trig_addr - pre_len_q;

endmodule
